// File: rtl/alu_pkg.sv
// Shared command encoding, compare-flag positions and FSM states for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_AND   = 4'd0,
        CMD_OR    = 4'd1,
        CMD_XOR   = 4'd2,
        CMD_NOT   = 4'd3,
        CMD_ADD_U = 4'd4,
        CMD_ADD_S = 4'd5,
        CMD_SUB_U = 4'd6,
        CMD_SUB_S = 4'd7,
        CMD_MUL_U = 4'd8,
        CMD_MUL_S = 4'd9,
        CMD_CMP_U = 4'd10,
        CMD_CMP_S = 4'd11,
        CMD_SLL   = 4'd12,
        CMD_SRL   = 4'd13,
        CMD_SRA   = 4'd14,
        CMD_RSVD  = 4'd15
    } cmd_e;

    localparam int CMP_LT = 0;
    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    function automatic logic is_mul_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MUL_U) || (cmd == CMD_MUL_S);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, product valid with done after SIZE cycles.
// Works on operand magnitudes; signed results are negated on the final cycle when operand signs differ.
module alu_mul_iter #(
    parameter int SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [SIZE-1:0]       a,
    input  logic [SIZE-1:0]       b,
    output logic                  done,
    output logic [2*SIZE-1:0]     product
);
    localparam int RESULT_SIZE = 2 * SIZE;
    localparam int CW          = $clog2(SIZE);

    logic                   busy;
    logic [CW-1:0]          cnt;
    logic [RESULT_SIZE-1:0] mcand;
    logic [RESULT_SIZE-1:0] acc;
    logic [RESULT_SIZE-1:0] acc_nxt;
    logic [SIZE-1:0]        mplier;
    logic                   neg;

    logic                   a_neg;
    logic                   b_neg;
    logic [SIZE-1:0]        a_mag;
    logic [SIZE-1:0]        b_mag;

    assign a_neg = signed_mode && a[SIZE-1];
    assign b_neg = signed_mode && b[SIZE-1];
    // The most negative value maps onto its own bit pattern, which is the correct unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == CW'(SIZE - 1));
    assign product = neg ? -acc_nxt : acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mcand  <= {{SIZE{1'b0}}, a_mag};
            acc    <= '0;
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= done ? '0 : cnt + CW'(1);
            busy   <= !done;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops visible the cycle after acceptance, multiplies after SIZE cycles.
// Stalled output holds result/overflow and drops in_ready; drain and accept at the same edge has no bubble.
module alu_seq
    import alu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            command,
    input  logic [SIZE-1:0]       a,
    input  logic [SIZE-1:0]       b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic [2*SIZE-1:0]     result
);
    localparam int RESULT_SIZE = 2 * SIZE;

    state_e                 state;
    state_e                 state_nxt;
    logic                   accept;
    logic                   cmd_is_mul;
    logic                   mul_done;
    logic [RESULT_SIZE-1:0] mul_product;

    logic [RESULT_SIZE-1:0] sc_res;
    logic                   sc_ov;
    logic [SIZE:0]          sum_u;
    logic [SIZE:0]          diff_u;
    logic [RESULT_SIZE-1:0] sll_w;
    logic                   big_shift;

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign cmd_is_mul = is_mul_cmd(command);

    alu_mul_iter #(.SIZE(SIZE)) u_mul (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (accept && cmd_is_mul),
        .signed_mode (command == CMD_MUL_S),
        .a           (a),
        .b           (b),
        .done        (mul_done),
        .product     (mul_product)
    );

    always_comb begin
        sc_res    = '0;
        sc_ov     = 1'b0;
        sum_u     = {1'b0, a} + {1'b0, b};
        diff_u    = {1'b0, a} - {1'b0, b};
        sll_w     = {{SIZE{1'b0}}, a} << b;
        big_shift = (b >= SIZE'(SIZE));
        case (cmd_e'(command))
            CMD_AND: sc_res[SIZE-1:0] = a & b;
            CMD_OR:  sc_res[SIZE-1:0] = a | b;
            CMD_XOR: sc_res[SIZE-1:0] = a ^ b;
            CMD_NOT: sc_res[SIZE-1:0] = ~a;
            CMD_ADD_U: begin
                sc_res[SIZE-1:0] = sum_u[SIZE-1:0];
                sc_ov            = sum_u[SIZE];
            end
            CMD_ADD_S: begin
                sc_res[SIZE-1:0] = sum_u[SIZE-1:0];
                sc_ov            = (a[SIZE-1] == b[SIZE-1]) && (sum_u[SIZE-1] != a[SIZE-1]);
            end
            CMD_SUB_U: begin
                sc_res[SIZE-1:0] = diff_u[SIZE-1:0];
                sc_ov            = diff_u[SIZE];
            end
            CMD_SUB_S: begin
                sc_res[SIZE-1:0] = diff_u[SIZE-1:0];
                sc_ov            = (a[SIZE-1] != b[SIZE-1]) && (diff_u[SIZE-1] != a[SIZE-1]);
            end
            CMD_MUL_U, CMD_MUL_S: begin
                sc_res = '0;
            end
            CMD_CMP_U: begin
                sc_res[CMP_LT] = a < b;
                sc_res[CMP_EQ] = a == b;
                sc_res[CMP_GT] = a > b;
            end
            CMD_CMP_S: begin
                sc_res[CMP_LT] = $signed(a) < $signed(b);
                sc_res[CMP_EQ] = a == b;
                sc_res[CMP_GT] = $signed(a) > $signed(b);
            end
            CMD_SLL: begin
                if (big_shift) begin
                    sc_ov = |a;
                end else begin
                    sc_res[SIZE-1:0] = sll_w[SIZE-1:0];
                    sc_ov            = |sll_w[RESULT_SIZE-1:SIZE];
                end
            end
            // Oversized shift amounts already saturate to zero / sign fill in SV semantics.
            CMD_SRL: sc_res[SIZE-1:0] = a >> b;
            CMD_SRA: sc_res[SIZE-1:0] = $signed(a) >>> b;
            CMD_RSVD: sc_ov = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && cmd_is_mul) state_nxt = MUL;
            MUL:  if (mul_done) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (accept && !cmd_is_mul) begin
            out_valid <= 1'b1;
            result    <= sc_res;
            overflow  <= sc_ov;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_product;
            overflow  <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
